// File: rtl/r_ptr_empty_if.sv
// r_ptr_empty_if -- read-side handshake bundle of an async FIFO.
//   slave  : the read-pointer/empty block (r_ptr_empty)
//   master : the read-side user (requests reads, supplies the synced write pointer)
// Signals:
//   r_en_i         read request
//   r_clr_i        clear sticky underflow
//   rw_ptr_i       Gray write pointer, already synchronized into the read domain
//   r_addr_o       binary RAM read address
//   r_ptr_o        registered Gray read pointer
//   r_empty_o      registered empty flag
//   r_valid_o      one-cycle RAM-data-valid pulse
//   r_underflow_o  sticky read-while-empty flag
//   r_level_o, r_almost_empty_o  only when FIFO_RD_LEVEL_EN is defined
interface r_ptr_empty_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 r_en_i;
  logic                 r_clr_i;
  logic [ADDR_SIZE:0]   rw_ptr_i;
  logic [ADDR_SIZE-1:0] r_addr_o;
  logic [ADDR_SIZE:0]   r_ptr_o;
  logic                 r_empty_o;
  logic                 r_valid_o;
  logic                 r_underflow_o;
`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_SIZE:0]   r_level_o;
  logic                 r_almost_empty_o;
`endif

  modport slave (
    input  r_en_i, r_clr_i, rw_ptr_i,
    output r_addr_o, r_ptr_o, r_empty_o, r_valid_o, r_underflow_o
`ifdef FIFO_RD_LEVEL_EN
    , output r_level_o, r_almost_empty_o
`endif
  );

  modport master (
    output r_en_i, r_clr_i, rw_ptr_i,
    input  r_addr_o, r_ptr_o, r_empty_o, r_valid_o, r_underflow_o
`ifdef FIFO_RD_LEVEL_EN
    , input r_level_o, r_almost_empty_o
`endif
  );
endinterface

// File: rtl/r_ptr_empty.sv
// r_ptr_empty -- read pointer and empty-flag generation for an async FIFO.
// Ports:
//   r_clk_i  read-domain clock
//   r_rst_i  asynchronous active-low reset (deassertion synchronized externally)
//   bus      r_ptr_empty_if.slave (see interface file for signal list)
// Optional feature macro: FIFO_RD_LEVEL_EN adds r_level_o / r_almost_empty_o.
// Parameters:
//   ADDR_SIZE  RAM address width; pointers are ADDR_SIZE+1 bits
//   AE_THRESH  almost-empty threshold in words (level feature only)
module r_ptr_empty #(
  parameter int ADDR_SIZE = 8,
  parameter int AE_THRESH = 4
) (
  input  logic          r_clk_i,
  input  logic          r_rst_i,
  r_ptr_empty_if.slave  bus
);

  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] rbin_next;
  logic [ADDR_SIZE:0] rgray_next;
  logic [ADDR_SIZE:0] rptr;
  logic               empty;
  logic               valid;
  logic               underflow;
  logic               accept;

  assign accept     = bus.r_en_i && !empty;
  assign rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, accept};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);

  always_ff @(posedge r_clk_i or negedge r_rst_i) begin
    if (!r_rst_i) begin
      rbin      <= '0;
      rptr      <= '0;
      empty     <= 1'b1;
      valid     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rbin  <= rbin_next;
      rptr  <= rgray_next;
      // Compare against the lagging synced write pointer: empty can only be
      // held high too long, never released early.
      empty <= (rgray_next == bus.rw_ptr_i);
      valid <= accept;
      // Set has priority over clear.
      if (bus.r_en_i && empty)
        underflow <= 1'b1;
      else if (bus.r_clr_i)
        underflow <= 1'b0;
    end
  end

  assign bus.r_addr_o      = rbin[ADDR_SIZE-1:0];
  assign bus.r_ptr_o       = rptr;
  assign bus.r_empty_o     = empty;
  assign bus.r_valid_o     = valid;
  assign bus.r_underflow_o = underflow;

`ifdef FIFO_RD_LEVEL_EN
  localparam logic [ADDR_SIZE:0] DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0] AE    = (ADDR_SIZE+1)'(AE_THRESH);

  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] level_raw;
  logic [ADDR_SIZE:0] level_next;
  logic [ADDR_SIZE:0] level;
  logic               almost_empty;

  // Gray to binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++)
      wbin[i] = ^(bus.rw_ptr_i >> i);
  end

  assign level_raw  = wbin - rbin_next;
  assign level_next = (level_raw > DEPTH) ? DEPTH : level_raw;

  always_ff @(posedge r_clk_i or negedge r_rst_i) begin
    if (!r_rst_i) begin
      level        <= '0;
      almost_empty <= 1'b1;
    end else begin
      level        <= level_next;
      almost_empty <= (level_next <= AE);
    end
  end

  assign bus.r_level_o        = level;
  assign bus.r_almost_empty_o = almost_empty;
`endif

endmodule

// File: tb/tb_r_ptr_empty.sv
// tb_r_ptr_empty -- directed scoreboard bench for r_ptr_empty (ADDR_SIZE=3).
// Each expected accept pushes its post-accept pointer/address; a monitor pops
// and compares on every r_valid_o pulse.
module tb_r_ptr_empty;
  localparam int AW = 3;

  logic r_clk_i = 1'b0;
  logic r_rst_i = 1'b0;

  r_ptr_empty_if #(.ADDR_SIZE(AW)) bus ();

  r_ptr_empty #(.ADDR_SIZE(AW), .AE_THRESH(4)) dut (
    .r_clk_i(r_clk_i),
    .r_rst_i(r_rst_i),
    .bus    (bus)
  );

  always #5 r_clk_i = ~r_clk_i;

  typedef struct {
    logic [AW:0]   ptr;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Gray codes 0..15, written out by hand.
  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge r_clk_i);
    #1;
  endtask

  task automatic rd(input logic [AW:0] p, input logic [AW-1:0] a);
    exp_t e;
    e.ptr  = p;
    e.addr = a;
    q.push_back(e);
    bus.r_en_i = 1'b1;
    step();
  endtask

  always @(negedge r_clk_i) begin
    if (r_rst_i && bus.r_valid_o) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL valid_pulse: got unexpected pulse, expected none at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        chk("valid_ptr", 32'(bus.r_ptr_o), 32'(mon_e.ptr));
        chk("valid_addr", 32'(bus.r_addr_o), 32'(mon_e.addr));
      end
    end
  end

  initial begin
    bus.r_en_i   = 1'b0;
    bus.r_clr_i  = 1'b0;
    bus.rw_ptr_i = '0;

    // Power-on reset values
    #12;
    chk("rst_empty", 32'(bus.r_empty_o), 32'd1);
    chk("rst_ptr", 32'(bus.r_ptr_o), 32'd0);
    chk("rst_addr", 32'(bus.r_addr_o), 32'd0);
    chk("rst_valid", 32'(bus.r_valid_o), 32'd0);
    chk("rst_uf", 32'(bus.r_underflow_o), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    chk("rst_level", 32'(bus.r_level_o), 32'd0);
    chk("rst_ae", 32'(bus.r_almost_empty_o), 32'd1);
`endif
    step();
    r_rst_i = 1'b1;
    step();
    chk("idle_empty", 32'(bus.r_empty_o), 32'd1);

    // Three words, four requests
    bus.rw_ptr_i = 4'b0010;
    step();
    chk("three_empty0", 32'(bus.r_empty_o), 32'd0);
    rd(4'b0001, 3'd1);
    rd(4'b0011, 3'd2);
    rd(4'b0010, 3'd3);
    chk("three_empty1", 32'(bus.r_empty_o), 32'd1);
    step();
    bus.r_en_i = 1'b0;
    chk("uf_set", 32'(bus.r_underflow_o), 32'd1);
    chk("uf_hold_ptr", 32'(bus.r_ptr_o), 32'b0010);
    chk("uf_hold_addr", 32'(bus.r_addr_o), 32'd3);

    // Set beats clear, then clear alone
    bus.r_clr_i = 1'b1;
    bus.r_en_i  = 1'b1;
    step();
    chk("uf_set_wins", 32'(bus.r_underflow_o), 32'd1);
    bus.r_en_i = 1'b0;
    step();
    chk("uf_clr", 32'(bus.r_underflow_o), 32'd0);
    bus.r_clr_i = 1'b0;

    // Advance to rbin=15, then wrap to 0
    bus.rw_ptr_i = gtab[15];
    step();
    chk("wrap_empty0", 32'(bus.r_empty_o), 32'd0);
    for (int i = 4; i < 16; i++)
      rd(gtab[i], 3'(i));
    bus.r_en_i = 1'b0;
    chk("r15_empty", 32'(bus.r_empty_o), 32'd1);
    chk("r15_ptr", 32'(bus.r_ptr_o), 32'b1000);
    chk("r15_addr", 32'(bus.r_addr_o), 32'd7);
    bus.rw_ptr_i = 4'b0000;
    step();
    chk("wrap_empty_pre", 32'(bus.r_empty_o), 32'd0);
    rd(4'b0000, 3'd0);
    bus.r_en_i = 1'b0;
    chk("wrap_empty", 32'(bus.r_empty_o), 32'd1);
    chk("wrap_ptr", 32'(bus.r_ptr_o), 32'd0);
    chk("wrap_addr", 32'(bus.r_addr_o), 32'd0);

    // Arm underflow, then reset in the middle of a read
    bus.r_en_i = 1'b1;
    step();
    bus.r_en_i = 1'b0;
    chk("uf_pre_rst", 32'(bus.r_underflow_o), 32'd1);
    bus.rw_ptr_i = gtab[7];
    step();
    bus.r_en_i = 1'b1;
    step();
    bus.r_en_i = 1'b0;
    chk("pre_rst_valid", 32'(bus.r_valid_o), 32'd1);
    #1;
    r_rst_i = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(bus.r_empty_o), 32'd1);
    chk("mid_rst_ptr", 32'(bus.r_ptr_o), 32'd0);
    chk("mid_rst_addr", 32'(bus.r_addr_o), 32'd0);
    chk("mid_rst_valid", 32'(bus.r_valid_o), 32'd0);
    chk("mid_rst_uf", 32'(bus.r_underflow_o), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    chk("mid_rst_level", 32'(bus.r_level_o), 32'd0);
    chk("mid_rst_ae", 32'(bus.r_almost_empty_o), 32'd1);
`endif
    bus.rw_ptr_i = '0;
    step();
    r_rst_i = 1'b1;
    step();

    // Eight words available, read four
    bus.rw_ptr_i = gtab[8];
    step();
    chk("full_empty", 32'(bus.r_empty_o), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    chk("full_level", 32'(bus.r_level_o), 32'd8);
    chk("full_ae", 32'(bus.r_almost_empty_o), 32'd0);
`endif
    rd(4'b0001, 3'd1);
    rd(4'b0011, 3'd2);
    rd(4'b0010, 3'd3);
    rd(4'b0110, 3'd4);
    bus.r_en_i = 1'b0;
    chk("half_empty", 32'(bus.r_empty_o), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    chk("half_level", 32'(bus.r_level_o), 32'd4);
    chk("half_ae", 32'(bus.r_almost_empty_o), 32'd1);
`endif

    step();
    step();
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/r_ptr_empty.md
R_PTR_EMPTY -- requirements
Module: r_ptr_empty

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8: RAM address width; FIFO depth 2^ADDR_SIZE; pointers ADDR_SIZE+1 bits.
REQ-002 SHALL have parameter AE_THRESH, default 4: almost-empty threshold in words; used only under FIFO_RD_LEVEL_EN.
REQ-003 SHALL have port r_clk_i  input  1  read-domain clock.
REQ-004 SHALL have port r_rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port r_en_i  input  1  read request.
REQ-006 SHALL have port r_clr_i  input  1  clears sticky underflow flag.
REQ-007 SHALL have port rw_ptr_i  input  ADDR_SIZE+1  Gray write pointer, already two-flop synchronized into r_clk_i domain.
REQ-008 SHALL have port r_addr_o  output  ADDR_SIZE  binary RAM read address.
REQ-009 SHALL have port r_ptr_o  output  ADDR_SIZE+1  registered Gray read pointer, for synchronization into the write domain.
REQ-010 SHALL have port r_empty_o  output  1  registered empty flag.
REQ-011 SHALL have port r_valid_o  output  1  one-cycle pulse: RAM read data valid.
REQ-012 SHALL have port r_underflow_o  output  1  sticky: read requested while empty.
REQ-013 SHALL have ports r_level_o (output, ADDR_SIZE+1, words available) and r_almost_empty_o (output, 1), only under FIFO_RD_LEVEL_EN.

Function
REQ-014 Accept SHALL be r_en_i && !r_empty_o; no other signal SHALL advance the read pointer.
REQ-015 On accept, binary pointer rbin SHALL increment modulo 2^(ADDR_SIZE+1); otherwise hold.
REQ-016 r_addr_o SHALL equal rbin[ADDR_SIZE-1:0], combinational from the rbin register.
REQ-017 r_ptr_o SHALL register rgray_next = rbin_next ^ (rbin_next >> 1), updating in the same edge as rbin; exactly one bit SHALL change per accept.
REQ-018 r_empty_o SHALL register (rgray_next == rw_ptr_i); it asserts the cycle after the last-word accept.
REQ-019 Empty SHALL be pessimistic: rw_ptr_i lag may hold empty high with data present; empty SHALL never deassert before a word is written.
REQ-020 Wrap: MSB SHALL distinguish laps; rbin 2^(ADDR_SIZE+1)-1 -> 0 with no special handling; r_addr_o wraps 2^ADDR_SIZE-1 -> 0.
REQ-021 r_valid_o SHALL register accept (synchronous RAM, 1-cycle read latency).
REQ-022 r_underflow_o SHALL set the cycle after r_en_i && r_empty_o, hold until r_clr_i; simultaneous set and clear: set wins.
REQ-023 Read while empty SHALL leave rbin, r_ptr_o, r_addr_o unchanged and produce no r_valid_o pulse.

Reset
REQ-024 r_rst_i low SHALL asynchronously force rbin=0, r_ptr_o=0, r_addr_o=0, r_empty_o=1, r_valid_o=0, r_underflow_o=0, r_level_o=0, r_almost_empty_o=1.
REQ-025 Reset mid-burst SHALL discard in-flight r_valid_o; deassertion is synchronous to r_clk_i via an external reset synchronizer.

Configuration
REQ-026 Macro FIFO_RD_LEVEL_EN defined: rw_ptr_i SHALL be Gray-to-binary converted (prefix XOR) to wbin; r_level_o SHALL register (wbin - rbin_next) mod 2^(ADDR_SIZE+1), clamped to 2^ADDR_SIZE; r_almost_empty_o SHALL register (level <= AE_THRESH).
REQ-027 Macro undefined: r_level_o, r_almost_empty_o, conversion logic SHALL be absent; all other behaviour identical.

Verification (ADDR_SIZE=3, AE_THRESH=4)
REQ-028 Reset asserted mid-operation -> immediately r_empty_o=1, r_ptr_o=0000, r_addr_o=000, r_valid_o=0, r_underflow_o=0.
REQ-029 rw_ptr_i=0010 (3 words), r_en_i high 4 cycles -> r_addr_o 0,1,2; r_ptr_o 0001,0011,0010; 3 r_valid_o pulses; r_empty_o=1 after third accept; fourth request sets r_underflow_o.
REQ-030 r_underflow_o=1, r_clr_i with simultaneous empty read -> stays 1; r_clr_i alone next cycle -> 0.
REQ-031 Wrap: advance rbin to 15 (r_ptr_o=1000), rw_ptr_i=0000 after one more write -> accept gives r_ptr_o=0000, r_addr_o 7->0, r_empty_o=1.
REQ-032 Macro on, rbin=0, rw_ptr_i=1100 (8 words) -> r_level_o=8, r_empty_o=0, r_almost_empty_o=0; after 4 accepts r_level_o=4, r_almost_empty_o=1.
